// File: rtl/program_sequencer.sv
// Host-side sequencer for the processor's Start/Ack run handshake: resets the core once,
// then launches up to MAX_PROGS programs and reports the measured cycle count of each.
module program_sequencer #(
   parameter int          MAX_PROGS     = 3,
   parameter int          CW            = 16,
   parameter int          RST_CYCLES    = 2,
   parameter int          START_CYCLES  = 2,
   parameter int unsigned TIMEOUT_LIMIT = 32'hFFFF,
   localparam int         PW            = $clog2(MAX_PROGS + 1)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Go,
   input  logic [PW-1:0] NumProgs,
   output logic          DutReset,
   output logic          DutStart,
   input  logic          DutAck,
   output logic          Busy,
   output logic          Done,
   output logic [PW-1:0] ProgIdx,
   output logic          ResultValid,
   output logic [CW-1:0] ResultCycles,
   output logic          Timeout
);

   localparam int PH_MAX = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
   localparam int PHW    = $clog2(PH_MAX + 1);
   localparam logic [PHW-1:0] RST_LAST   = PHW'(RST_CYCLES - 1);
   localparam logic [PHW-1:0] START_LAST = PHW'(START_CYCLES - 1);
   localparam logic [CW-1:0]  LIMIT      = CW'(TIMEOUT_LIMIT);
   localparam logic [PW:0]    MAX_P      = (PW + 1)'(MAX_PROGS);

   typedef enum logic [2:0] {IDLE, RESET_DUT, START, WAIT_ACK, DONE} stateT;

   stateT          stateReg, stateNext;
   logic [PHW-1:0] phaseReg, phaseNext;
   logic [CW-1:0]  cycleReg, cycleNext;
   logic [PW-1:0]  numProgsReg, numProgsNext;
   logic [PW-1:0]  progIdxReg, progIdxNext;
   logic           resultValidReg, resultValidNext;
   logic [CW-1:0]  resultCyclesReg, resultCyclesNext;
   logic           timeoutReg, timeoutNext;
   logic           dutResetReg, dutStartReg, busyReg, doneReg;
   logic [PW-1:0]  progsClamped;
   logic           lastProg;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         stateReg        <= IDLE;
         phaseReg        <= '0;
         cycleReg        <= '0;
         numProgsReg     <= '0;
         progIdxReg      <= '0;
         resultValidReg  <= 1'b0;
         resultCyclesReg <= '0;
         timeoutReg      <= 1'b0;
         dutResetReg     <= 1'b1;
         dutStartReg     <= 1'b0;
         busyReg         <= 1'b0;
         doneReg         <= 1'b0;
      end else begin
         stateReg        <= stateNext;
         phaseReg        <= phaseNext;
         cycleReg        <= cycleNext;
         numProgsReg     <= numProgsNext;
         progIdxReg      <= progIdxNext;
         resultValidReg  <= resultValidNext;
         resultCyclesReg <= resultCyclesNext;
         timeoutReg      <= timeoutNext;
         dutResetReg     <= (stateNext == RESET_DUT);
         dutStartReg     <= (stateNext == START);
         busyReg         <= (stateNext != IDLE) && (stateNext != DONE);
         doneReg         <= (stateNext == DONE);
      end
   end

   always_comb begin
      stateNext        = stateReg;
      phaseNext        = phaseReg;
      cycleNext        = cycleReg;
      numProgsNext     = numProgsReg;
      progIdxNext      = progIdxReg;
      resultValidNext  = 1'b0;
      resultCyclesNext = resultCyclesReg;
      timeoutNext      = timeoutReg;
      progsClamped     = ({1'b0, NumProgs} > MAX_P) ? PW'(MAX_PROGS) : NumProgs;
      lastProg         = (({1'b0, progIdxReg} + (PW + 1)'(1)) >= {1'b0, numProgsReg});

      case (stateReg)
         IDLE: begin
            if (Go) begin
               numProgsNext     = progsClamped;
               timeoutNext      = 1'b0;
               resultCyclesNext = '0;
               progIdxNext      = '0;
               phaseNext        = '0;
               stateNext        = (progsClamped == '0) ? DONE : RESET_DUT;
            end
         end
         RESET_DUT: begin
            if (phaseReg == RST_LAST) begin
               phaseNext = '0;
               stateNext = START;
            end else begin
               phaseNext = phaseReg + PHW'(1);
            end
         end
         START: begin
            if (phaseReg == START_LAST) begin
               phaseNext = '0;
               cycleNext = '0;
               stateNext = WAIT_ACK;
            end else begin
               phaseNext = phaseReg + PHW'(1);
            end
         end
         WAIT_ACK: begin
            // The cycle after a result pulse decides between the next program and DONE.
            if (resultValidReg) begin
               if (timeoutReg || lastProg) begin
                  stateNext = DONE;
               end else begin
                  progIdxNext = progIdxReg + PW'(1);
                  phaseNext   = '0;
                  stateNext   = START;
               end
            end else if (cycleReg == '0) begin
               cycleNext = CW'(1);
            end else if (DutAck) begin
               resultValidNext  = 1'b1;
               resultCyclesNext = cycleReg;
            end else if (cycleReg == LIMIT) begin
               timeoutNext      = 1'b1;
               resultValidNext  = 1'b1;
               resultCyclesNext = LIMIT;
            end else begin
               cycleNext = cycleReg + CW'(1);
            end
         end
         DONE: begin
            if (!Go) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign DutReset     = dutResetReg;
   assign DutStart     = dutStartReg;
   assign Busy         = busyReg;
   assign Done         = doneReg;
   assign ProgIdx      = progIdxReg;
   assign ResultValid  = resultValidReg;
   assign ResultCycles = resultCyclesReg;
   assign Timeout      = timeoutReg;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench: instance 0 uses the default timeout, instance 1 a timeout of 8 cycles;
// a per-instance processor model answers each DutStart with a programmable Ack latency.
module tb_program_sequencer;

   localparam int NI = 2;
   localparam int PW = 2;
   localparam int CW = 16;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic          rstN;
   logic [NI-1:0] go;
   logic [PW-1:0] numProgs [NI];
   logic [NI-1:0] dutReset, dutStart, busy, done, resultValid, timeout;
   logic [NI-1:0] dutAck = '0;
   logic [PW-1:0] progIdx [NI];
   logic [CW-1:0] resultCycles [NI];

   for (genvar gi = 0; gi < NI; gi++) begin : gDut
      program_sequencer #(
         .TIMEOUT_LIMIT((gi == 0) ? 32'hFFFF : 32'd8)
      ) uDut (
         .Clk(Clk), .Reset(rstN), .Go(go[gi]), .NumProgs(numProgs[gi]),
         .DutReset(dutReset[gi]), .DutStart(dutStart[gi]), .DutAck(dutAck[gi]),
         .Busy(busy[gi]), .Done(done[gi]), .ProgIdx(progIdx[gi]),
         .ResultValid(resultValid[gi]), .ResultCycles(resultCycles[gi]), .Timeout(timeout[gi])
      );
   end

   int checks = 0;
   int failures = 0;

   // Processor model and monitor state
   int   latTab [NI][4] = '{default: 1000};
   int   cnt [NI]       = '{default: 0};
   int   pn [NI]        = '{default: 0};
   logic armed [NI]     = '{default: 1'b0};
   logic prevStart [NI] = '{default: 1'b0};
   logic prevReset [NI] = '{default: 1'b1};
   int   rstCyc [NI]    = '{default: 0};
   int   rstRise [NI]   = '{default: 0};
   int   startCyc [NI]  = '{default: 0};
   int   startRise [NI] = '{default: 0};
   int   resN [NI]      = '{default: 0};
   int   resC [NI][16]  = '{default: 0};
   int   resI [NI][16]  = '{default: 0};
   int   expRes [3]     = '{5, 1, 20};

   always @(negedge Clk) begin
      for (int i = 0; i < NI; i++) begin
         if (!rstN || dutReset[i]) begin
            armed[i]  <= 1'b0;
            dutAck[i] <= 1'b0;
            pn[i]     <= 0;
            cnt[i]    <= 0;
         end else if (dutStart[i]) begin
            // Ack is left at its stale value while Start is high.
            if (!prevStart[i] && armed[i]) pn[i] <= pn[i] + 1;
            armed[i] <= 1'b1;
            cnt[i]   <= 0;
         end else if (armed[i]) begin
            dutAck[i] <= (cnt[i] >= latTab[i][pn[i]]);
            cnt[i]    <= cnt[i] + 1;
         end
         prevStart[i] <= dutStart[i];
         prevReset[i] <= dutReset[i];
         if (rstN) begin
            if (dutReset[i]) rstCyc[i] <= rstCyc[i] + 1;
            if (dutReset[i] && !prevReset[i]) rstRise[i] <= rstRise[i] + 1;
            if (dutStart[i]) startCyc[i] <= startCyc[i] + 1;
            if (dutStart[i] && !prevStart[i]) startRise[i] <= startRise[i] + 1;
            if (resultValid[i]) begin
               if (resN[i] < 16) begin
                  resC[i][resN[i]] <= int'(resultCycles[i]);
                  resI[i][resN[i]] <= int'(progIdx[i]);
               end
               resN[i] <= resN[i] + 1;
            end
         end
      end
   end

   int bRstCyc, bRstRise, bStartCyc, bStartRise, bRes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge Clk);
      #1;
   endtask

   task automatic snap(input int i);
      bRstCyc    = rstCyc[i];
      bRstRise   = rstRise[i];
      bStartCyc  = startCyc[i];
      bStartRise = startRise[i];
      bRes       = resN[i];
   endtask

   task automatic waitDone(input int i, input int budget);
      int n;
      n = 0;
      while (!done[i] && n < budget) begin
         cyc();
         n++;
      end
      chk("done_reached", done[i], 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rstN        = 1'b0;
      go          = '0;
      numProgs[0] = '0;
      numProgs[1] = '0;
      repeat (3) cyc();

      // Reset state
      chk("rst_dutReset", dutReset[0], 1'b1);
      chk("rst_dutStart", dutStart[0], 1'b0);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_done", done[0], 1'b0);
      chk("rst_resultValid", resultValid[0], 1'b0);
      chk("rst_timeout", timeout[0], 1'b0);
      chk("rst_progIdx", progIdx[0], 2'd0);
      chk("rst_resultCycles", resultCycles[0], 16'd0);
      rstN = 1'b1;
      cyc();
      chk("idle_dutReset", dutReset[0], 1'b0);
      chk("idle_busy", busy[0], 1'b0);

      // Single program, Ack 10 cycles after Start falls
      snap(0);
      latTab[0][0] = 10;
      numProgs[0]  = 2'd1;
      go[0]        = 1'b1;
      cyc();
      chk("t1_busy", busy[0], 1'b1);
      chk("t1_dutReset", dutReset[0], 1'b1);
      waitDone(0, 100);
      chk("t1_rstCyc", rstCyc[0] - bRstCyc, 2);
      chk("t1_rstRise", rstRise[0] - bRstRise, 1);
      chk("t1_startCyc", startCyc[0] - bStartCyc, 2);
      chk("t1_startRise", startRise[0] - bStartRise, 1);
      chk("t1_resN", resN[0] - bRes, 1);
      chk("t1_res0", resC[0][bRes], 10);
      chk("t1_idx0", resI[0][bRes], 0);
      chk("t1_busy_done", busy[0], 1'b0);
      chk("t1_timeout", timeout[0], 1'b0);
      cyc();
      chk("t1_done_hold_go", done[0], 1'b1);
      chk("t1_no_restart", rstRise[0] - bRstRise, 1);
      go[0] = 1'b0;
      cyc();
      chk("t1_done_clear", done[0], 1'b0);

      // Three programs 5/1/20, stale Ack during Start, Go toggled mid-run
      snap(0);
      latTab[0][0] = 5;
      latTab[0][1] = 1;
      latTab[0][2] = 20;
      numProgs[0]  = 2'd3;
      go[0]        = 1'b1;
      repeat (3) cyc();
      go[0] = 1'b0;
      repeat (3) cyc();
      go[0] = 1'b1;
      waitDone(0, 120);
      chk("t2_rstRise", rstRise[0] - bRstRise, 1);
      chk("t2_rstCyc", rstCyc[0] - bRstCyc, 2);
      chk("t2_startRise", startRise[0] - bStartRise, 3);
      chk("t2_startCyc", startCyc[0] - bStartCyc, 6);
      chk("t2_resN", resN[0] - bRes, 3);
      chk("t2_res0", resC[0][bRes], 5);
      chk("t2_res1", resC[0][bRes + 1], 1);
      chk("t2_res2", resC[0][bRes + 2], 20);
      chk("t2_idx0", resI[0][bRes], 0);
      chk("t2_idx1", resI[0][bRes + 1], 1);
      chk("t2_idx2", resI[0][bRes + 2], 2);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (resC[0][bRes + k] !== expRes[k] || resI[0][bRes + k] !== k) begin
            failures++;
            $error("FAIL t2_loop k=%0d cycles=%0d idx=%0d expected=%0d/%0d",
                   k, resC[0][bRes + k], resI[0][bRes + k], expRes[k], k);
         end
      end
      chk("t2_progIdx_last", progIdx[0], 2'd2);
      chk("t2_timeout", timeout[0], 1'b0);
      go[0] = 1'b0;
      cyc();

      // Timeout at 8 with three programs requested
      snap(1);
      numProgs[1] = 2'd3;
      go[1]       = 1'b1;
      waitDone(1, 60);
      chk("t3_timeout", timeout[1], 1'b1);
      chk("t3_resultCycles", resultCycles[1], 16'd8);
      chk("t3_resN", resN[1] - bRes, 1);
      chk("t3_res0", resC[1][bRes], 8);
      chk("t3_startRise", startRise[1] - bStartRise, 1);
      go[1] = 1'b0;
      repeat (2) cyc();
      chk("t3_timeout_held", timeout[1], 1'b1);
      chk("t3_result_held", resultCycles[1], 16'd8);

      // Ack exactly when the counter reaches the limit counts as success
      snap(1);
      latTab[1][0] = 8;
      numProgs[1]  = 2'd1;
      go[1]        = 1'b1;
      cyc();
      chk("t4_timeout_cleared", timeout[1], 1'b0);
      waitDone(1, 60);
      chk("t4_timeout", timeout[1], 1'b0);
      chk("t4_resultCycles", resultCycles[1], 16'd8);
      chk("t4_resN", resN[1] - bRes, 1);
      go[1] = 1'b0;
      cyc();

      // Zero programs
      snap(0);
      numProgs[0] = 2'd0;
      go[0]       = 1'b1;
      waitDone(0, 2);
      chk("t5_rstRise", rstRise[0] - bRstRise, 0);
      chk("t5_startRise", startRise[0] - bStartRise, 0);
      chk("t5_resN", resN[0] - bRes, 0);
      go[0] = 1'b0;
      cyc();

      // Asynchronous reset in the middle of WAIT_ACK
      snap(0);
      latTab[0][0] = 10;
      numProgs[0]  = 2'd1;
      go[0]        = 1'b1;
      repeat (7) cyc();
      chk("t6_busy_wait", busy[0], 1'b1);
      #2;
      rstN = 1'b0;
      #1;
      chk("t6_dutReset", dutReset[0], 1'b1);
      chk("t6_dutStart", dutStart[0], 1'b0);
      chk("t6_busy", busy[0], 1'b0);
      chk("t6_done", done[0], 1'b0);
      chk("t6_resultValid", resultValid[0], 1'b0);
      chk("t6_progIdx", progIdx[0], 2'd0);
      chk("t6_resultCycles", resultCycles[0], 16'd0);
      cyc();
      rstN  = 1'b1;
      go[0] = 1'b0;
      repeat (4) cyc();
      chk("t6_idle_busy", busy[0], 1'b0);
      chk("t6_idle_done", done[0], 1'b0);
      chk("t6_idle_dutReset", dutReset[0], 1'b0);
      chk("t6_idle_dutStart", dutStart[0], 1'b0);
      chk("t6_no_result", resN[0] - bRes, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Host-side initiator for the processor's Start/Ack run handshake; it is the other end of the interface the processor core exposes.
- Resets the DUT, then launches up to MAX_PROGS consecutive programs by pulsing DutStart.
- After each launch it waits for DutAck, measures the cycles to completion, and reports one result per program.
- It also aborts a run with a sticky timeout if DutAck never arrives. It sits in the test harness or SoC wrapper between the host/bench and the processor top level.

Parameters:
- MAX_PROGS, 3: maximum programs per session; PW = $clog2(MAX_PROGS+1).
- CW, 16: cycle counter and result width.
- RST_CYCLES, 2: cycles DutReset is held high. Must be at least 1.
- START_CYCLES, 2: cycles DutStart is held high per program. Must be at least 1.
- TIMEOUT_LIMIT, 16'hFFFF: WAIT_ACK cycle count at which a run is aborted. Must be at least 1.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Go  in  1  session request; accepted only in IDLE.
- NumProgs  in  PW  programs to run; latched when Go is accepted.
- DutReset  out  1  active-high reset to the processor.
- DutStart  out  1  active-high start to the processor.
- DutAck  in  1  done flag from the processor; combinational at the DUT, same clock domain.
- Busy  out  1  high in every state except IDLE and DONE.
- Done  out  1  session finished.
- ProgIdx  out  PW  index of the current or last program, 0-based.
- ResultValid  out  1  one-cycle pulse when a result is available.
- ResultCycles  out  CW  measured cycles for the program given by ProgIdx.
- Timeout  out  1  sticky flag: a run was aborted.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state = IDLE.
  - DutReset = 1 (DUT is held in reset while the sequencer is in reset).
  - DutStart, Busy, Done, ResultValid and Timeout = 0.
  - ProgIdx = 0, ResultCycles = 0, internal counters = 0.
  - Reset asserted mid-run aborts immediately; no result is produced.
- All outputs are registered.
- State machine:
  - IDLE: DutReset = 0. On Go=1: latch NumProgs, clear Timeout, ProgIdx <= 0. If NumProgs==0, go to DONE; otherwise go to RESET_DUT.
  - RESET_DUT: DutReset = 1 for exactly RST_CYCLES cycles, then go to START.
  - START: DutStart = 1 for exactly START_CYCLES cycles. DutAck is ignored here, because a stale Ack from the previous program's halt is expected. Then go to WAIT_ACK and clear the cycle counter to 0.
  - WAIT_ACK, blanking: the first WAIT_ACK cycle is blanked. DutAck is not sampled, and the counter increments.
  - WAIT_ACK, normal cycles: if DutAck=1, then ResultCycles <= counter and ResultValid pulses for one cycle. ProgIdx holds the finished program's index during the pulse.
  - WAIT_ACK, after a result: if ProgIdx+1 < latched NumProgs, go to START and increment ProgIdx in the same cycle ResultValid drops. Otherwise go to DONE.
  - WAIT_ACK, no Ack: if DutAck=0, the counter increments.
  - Timeout: if the counter == TIMEOUT_LIMIT and DutAck=0, then Timeout <= 1, ResultCycles <= TIMEOUT_LIMIT and ResultValid pulses. Go to DONE; remaining programs are skipped.
  - DONE: Done = 1, Busy = 0. Hold until Go=0, then return to IDLE with Done = 0. Timeout and ResultCycles are held until the next accepted Go.
- Reset of the DUT happens only once per session. Between programs only DutStart is pulsed, matching the core's "start next program" semantics.
- Counter arithmetic:
  - The counter is CW-bit unsigned and never wraps. Timeout fires before it can exceed TIMEOUT_LIMIT.
  - ResultCycles = number of WAIT_ACK cycles preceding the cycle in which DutAck is sampled high. Minimum legal result is 1, because of blanking.
- Simultaneous events:
  - DutAck=1 on the same cycle the counter == TIMEOUT_LIMIT counts as success, not timeout.
  - Go is ignored outside IDLE, including Go toggling mid-run.
  - Go held high through DONE does not restart a session; it must drop first.
- NumProgs > MAX_PROGS is clamped to MAX_PROGS at latch time.

Test Plan:
- Reset release, then Go=1 with NumProgs=1; DUT model raises Ack 10 cycles after DutStart falls -> DutReset high 2 cycles, DutStart high 2 cycles, ResultValid pulse with ResultCycles=10 and ProgIdx=0, then Done=1 and Busy=0; Done clears after Go=0.
- NumProgs=3; DUT Ack latencies 5, 1, 20; Ack left high between programs -> DutReset pulses once only, three DutStart pulses, results 5/1/20 with ProgIdx 0/1/2, and stale Ack during START causes no false result.
- TIMEOUT_LIMIT=8, DUT never Acks -> after 8 WAIT cycles Timeout=1, ResultCycles=8 and one ResultValid pulse; with NumProgs=3, no further DutStart; Done=1.
- TIMEOUT_LIMIT=8, Ack arrives exactly when the counter==8 -> success: Timeout=0, ResultCycles=8.
- NumProgs=0 -> no DutReset/DutStart pulses and no ResultValid; Done=1 within 2 cycles of Go.
- Reset driven low mid-WAIT_ACK -> all outputs go to reset values asynchronously (DutReset=1, others 0); after release the FSM sits in IDLE until the next Go.
